// File: rtl/code_sequencer_pkg.sv
// code_seq_pkg: types and constants shared by the code_sequencer block.
//   state_e   : scheduler FSM states (IDLE, GRANT, GAP)
//   CODE_OFF  : lane code that switches every decoder lane off
//   LANES     : number of requesters / decoder lanes
//   lane2code : lane index (0..7) -> decoder lane code (1..8)
package code_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [3:0] CODE_OFF = 4'd0;
    localparam int         LANES    = 8;

    function automatic logic [3:0] lane2code(input logic [2:0] lane);
        return {1'b0, lane} + 4'd1;
    endfunction

endpackage

// File: rtl/code_sequencer_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i   [7:0] : level requests, bit i = lane i
//   ptr_i   [2:0] : highest-priority lane for this pick
//   valid_o       : at least one request is set
//   idx_o   [2:0] : first set request at or after ptr_i, searching cyclically
module rr_pick
    import code_seq_pkg::*;
(
    input  logic [LANES-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic             valid_o,
    output logic [2:0]       idx_o
);

    logic [2*LANES-1:0] dbl;
    logic [LANES-1:0]   rot;
    logic [2:0]         off;

    always_comb begin
        // Rotate so that lane ptr_i lands on bit 0, then lowest-set-bit wins.
        dbl     = {req_i, req_i} >> ptr_i;
        rot     = dbl[LANES-1:0];
        valid_o = |req_i;
        off     = 3'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        // 3-bit add wraps, which undoes the rotation.
        idx_o = off + ptr_i;
    end

endmodule

// File: rtl/code_sequencer.sv
// code_sequencer: round-robin scheduler that shares one 8-lane one-hot decoder
// among 8 requesters. Each grant lasts a programmed dwell and is followed by an
// all-off gap so the downstream registered decoder breaks before it makes.
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset
//   en         : scheduler enable
//   req  [7:0] : level requests, bit i -> lane code i+1
//   cfg_dwell  : grant length in cycles (0 selects DWELL_DEF), sampled at grant start
//   code [3:0] : registered lane code, 0 = all off, k = lane k-1
//   busy       : registered, high whenever the FSM is not IDLE
//   done       : registered one-cycle pulse on the first cycle after a grant ends
//   state_dbg  : current FSM state, for observation only
module code_sequencer
    import code_seq_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DWELL_DEF = 16,
    parameter int GAP_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       req,
    input  logic [CNT_W-1:0] cfg_dwell,
    output logic [3:0]       code,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] DWELL_D = CNT_W'(DWELL_DEF);
    localparam logic [CNT_W-1:0] GAP_W   = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       lane_q, lane_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;     // grant cycle count in GRANT, gap count in GAP
    logic [3:0]       code_q, code_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             pick_valid;
    logic [2:0]       pick_idx;
    logic             start;            // a new grant begins next cycle
    logic             grant_end;        // current grant ends this cycle

    rr_pick u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // State register, including the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            lane_q  <= 3'd0;
            dwell_q <= '0;
            cnt_q   <= '0;
            code_q  <= CODE_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lane_q  <= lane_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lane_d    = lane_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        start     = 1'b0;
        grant_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && pick_valid) start = 1'b1;
            end
            GRANT: begin
                // Expiry, release and disable all collapse into one exit.
                if (cnt_q == dwell_q || !req[lane_q] || !en) begin
                    grant_end = 1'b1;
                    state_d   = GAP;
                    cnt_d     = ONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_W) begin
                    // Chain straight into the next grant to avoid an idle cycle.
                    if (en && pick_valid) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (start) begin
            state_d = GRANT;
            lane_d  = pick_idx;
            ptr_d   = pick_idx + 3'd1;
            dwell_d = (cfg_dwell == '0) ? DWELL_D : cfg_dwell;
            cnt_d   = ONE;
        end
    end

    // Output logic: outputs are registered, so derive them from the next state.
    always_comb begin
        code_d = (state_d == GRANT) ? lane2code(lane_d) : CODE_OFF;
        busy_d = (state_d != IDLE);
        done_d = grant_end;
    end

    assign code      = code_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_code_sequencer.sv
module tb_code_sequencer;

    localparam int CNT_W     = 16;
    localparam int DWELL_DEF = 16;
    localparam int GAP_CYC   = 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic [7:0]       req;
    logic [CNT_W-1:0] cfg_dwell;
    logic [3:0]       code;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    int    checks = 0;
    int    errors = 0;
    string tag    = "init";

    // Reference model: lane in service (-1 = none), grant cycles left,
    // gap cycles left, round-robin start lane.
    int       m_lane = -1;
    int       m_left = 0;
    int       m_gap  = 0;
    int       m_ptr  = 0;
    bit       m_done = 0;
    bit       m_busy = 0;
    logic [3:0] exp_q[$];

    code_sequencer #(
        .CNT_W     (CNT_W),
        .DWELL_DEF (DWELL_DEF),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .cfg_dwell (cfg_dwell),
        .code      (code),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic try_pick();
        for (int k = 0; k < 8; k++) begin
            int l;
            l = (m_ptr + k) % 8;
            if (req[l]) begin
                m_lane = l;
                m_ptr  = (l + 1) % 8;
                m_left = (cfg_dwell == 0) ? DWELL_DEF : int'(cfg_dwell);
                return;
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        m_done = 1'b0;
        if (rst) begin
            m_lane = -1;
            m_left = 0;
            m_gap  = 0;
            m_ptr  = 0;
        end else if (m_lane >= 0) begin
            if (m_left == 1 || !req[m_lane] || !en) begin
                m_lane = -1;
                m_gap  = GAP_CYC;
                m_done = 1'b1;
            end else begin
                m_left--;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            if (en) try_pick();
        end
        m_busy = (m_lane >= 0) || (m_gap > 0);
        exp_q.push_back((m_lane >= 0) ? 4'(m_lane + 1) : 4'd0);
    endtask

    // Scoreboard compare
    task automatic check_outputs();
        logic [3:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (code === e) else begin
            errors++;
            $error("FAIL %s code: got %0d expected %0d", tag, code, e);
        end
        checks++;
        assert (done === m_done) else begin
            errors++;
            $error("FAIL %s done: got %0b expected %0b", tag, done, m_done);
        end
        checks++;
        assert (busy === m_busy) else begin
            errors++;
            $error("FAIL %s busy: got %0b expected %0b", tag, busy, m_busy);
        end
        checks++;
        assert ((state_dbg != 2'd0) === m_busy) else begin
            errors++;
            $error("FAIL %s state_active: got %0b expected %0b", tag, state_dbg != 2'd0, m_busy);
        end
    endtask

    // Driver: one clock, then compare 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Run until the model expects the given code, bounded.
    task automatic run_until_code(input logic [3:0] c, input int limit);
        int n;
        n = 0;
        while (!(m_lane >= 0 && 4'(m_lane + 1) == c) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        assert (n < limit) else begin
            errors++;
            $error("FAIL %s wait_code%0d: got timeout after %0d expected grant", tag, c, n);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        req       = 8'hFF;
        cfg_dwell = 16'd4;

        // 1: reset held with all requests pending
        tag = "reset";
        ticks(3);
        rst = 1'b0;

        // 2: all lanes requesting, dwell 4 -> 1..8 then wrap to 1
        tag = "rr_all";
        ticks(8 * 5 + 6);

        // 3: single lane 4, default dwell
        tag = "dwell_def";
        req       = 8'h10;
        cfg_dwell = 16'd0;
        ticks(45);

        // 4: early release of lane 2 at count 3, next pick from lane 3
        tag = "early_rel";
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req       = 8'h04;
        cfg_dwell = 16'd10;
        run_until_code(4'd3, 10);
        ticks(2);
        req = 8'h00;
        ticks(3);
        req = 8'hFF;
        ticks(6);

        // 5: enable dropped mid-grant, then held low with requests
        tag = "en_drop";
        ticks(2);
        en = 1'b0;
        ticks(12);
        en = 1'b1;
        ticks(3);

        // 6: reset in GRANT at count 2, then req 0x81 grants lane 0 first
        tag = "rst_grant";
        run_until_code(4'd1, 60);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h81;
        cfg_dwell = 16'd3;
        ticks(14);

        // Randomized traffic
        tag = "random";
        for (int i = 0; i < 600; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 59) == 0);
            cfg_dwell = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0) req = 8'($urandom_range(0, 255));
            tick();
        end
        rst = 1'b0;
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
